// File: rtl/ahb_master_arbiter_if.sv
// Bus-side signal bundle for the two-master AHB arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/fabric view.
interface ahb_master_arbiter_if;
    logic HBUSREQ_M1;
    logic HBUSREQ_M2;
    logic HREADY_S;
    logic HGRANT_M1;
    logic HGRANT_M2;
    logic HREADY_M1;
    logic HREADY_M2;
    logic HMASTER_A;
    logic HTRANS_A;
    logic HMASTER_D;
    logic HRESP_ERR;
    logic busy_o;

    modport slave (
        input  HBUSREQ_M1, HBUSREQ_M2, HREADY_S,
        output HGRANT_M1, HGRANT_M2, HREADY_M1, HREADY_M2,
               HMASTER_A, HTRANS_A, HMASTER_D, HRESP_ERR, busy_o
    );

    modport master (
        output HBUSREQ_M1, HBUSREQ_M2, HREADY_S,
        input  HGRANT_M1, HGRANT_M2, HREADY_M1, HREADY_M2,
               HMASTER_A, HTRANS_A, HMASTER_D, HRESP_ERR, busy_o
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master, single-outstanding AHB arbiter: M2 preferred, M1 protected from starvation,
// hung data phases terminated with an error pulse after TIMEOUT stalled cycles.
module ahb_master_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_master_arbiter_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_e;

    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT - 1);
    localparam logic        TMO_EN_C   = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic        hmaster_d_q, hmaster_d_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    logic in_data, timeout_hit, window, m1_prio;
    logic gnt1, gnt2, grant, rsp;

    always_comb begin
        in_data     = (state_q == DATA);
        // Fires in the TIMEOUT-th consecutive stalled data cycle.
        timeout_hit = in_data && !bus.HREADY_S && TMO_EN_C && (tmo_cnt_q == TMO_LAST_C);
        window      = (!in_data || bus.HREADY_S) && !timeout_hit;
        m1_prio     = (starve_cnt_q >= MAX_WAIT_C);
        gnt1        = window && bus.HBUSREQ_M1 && (!bus.HBUSREQ_M2 || m1_prio);
        gnt2        = window && bus.HBUSREQ_M2 && !gnt1;
        grant       = gnt1 || gnt2;
        rsp         = in_data && (bus.HREADY_S || timeout_hit);

        state_d     = state_q;
        hmaster_d_d = hmaster_d_q;
        if (grant) begin
            state_d     = DATA;
            hmaster_d_d = gnt2;
        end else if (rsp) begin
            state_d     = IDLE;
        end

        starve_cnt_d = starve_cnt_q;
        if (!bus.HBUSREQ_M1 || gnt1)
            starve_cnt_d = '0;
        else if (starve_cnt_q < MAX_WAIT_C)
            starve_cnt_d = starve_cnt_q + 8'd1;

        tmo_cnt_d = tmo_cnt_q;
        if (grant || rsp)
            tmo_cnt_d = '0;
        else if (in_data && !bus.HREADY_S)
            tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            hmaster_d_q  <= 1'b0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            hmaster_d_q  <= hmaster_d_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.HGRANT_M1 = gnt1;
    assign bus.HGRANT_M2 = gnt2;
    assign bus.HTRANS_A  = grant;
    assign bus.HMASTER_A = grant ? gnt2 : hmaster_d_q;
    assign bus.HMASTER_D = hmaster_d_q;
    assign bus.HREADY_M1 = rsp && !hmaster_d_q;
    assign bus.HREADY_M2 = rsp && hmaster_d_q;
    assign bus.HRESP_ERR = timeout_hit;
    assign bus.busy_o    = in_data;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a transaction-level model.
module tb_ahb_master_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int TIMEOUT  = 4;

    logic HCLK;
    logic HRESETn;
    ahb_master_arbiter_if bus();

    ahb_master_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int compared = 0;
    int mismatched = 0;

    // Model: whether a transfer is outstanding, who owns it, how long M1 has waited,
    // and how many stalled data cycles have elapsed.
    int m_busy, m_owner, m_starve, m_stall;
    int last_win;
    logic [8:0] last_obs;

    function automatic logic [8:0] observe();
        return {bus.HGRANT_M1, bus.HGRANT_M2, bus.HREADY_M1, bus.HREADY_M2, bus.HMASTER_A,
                bus.HTRANS_A, bus.HMASTER_D, bus.HRESP_ERR, bus.busy_o};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_starve = 0; m_stall = 0;
    endtask

    task automatic cyc(input logic r1, input logic r2, input logic rdy, input string tag);
        int win;
        bit tmo, open, rsp;
        logic [8:0] exp;
        bus.HBUSREQ_M1 = r1;
        bus.HBUSREQ_M2 = r2;
        bus.HREADY_S   = rdy;
        #4;
        tmo  = (m_busy != 0) && !rdy && (TIMEOUT != 0) && (m_stall + 1 >= TIMEOUT);
        open = ((m_busy == 0) || rdy) && !tmo;
        win  = -1;
        if (open) begin
            if (r1 && r2)  win = (m_starve >= MAX_WAIT) ? 0 : 1;
            else if (r1)   win = 0;
            else if (r2)   win = 1;
        end
        rsp = (m_busy != 0) && (rdy || tmo);
        exp = {win == 0, win == 1, rsp && m_owner == 0, rsp && m_owner == 1,
               (win >= 0) ? win[0] : m_owner[0], win >= 0, m_owner[0], tmo, m_busy != 0};
        last_obs = observe();
        check(tag, last_obs, exp);
        last_win = win;
        @(posedge HCLK);
        if (win >= 0)      begin m_busy = 1; m_owner = win; m_stall = 0; end
        else if (rsp)      begin m_busy = 0; m_stall = 0; end
        else if (m_busy != 0) m_stall++;
        if (r1 && win != 0) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
        else                m_starve = 0;
        #1;
    endtask

    initial begin
        logic [17:0] seq_got, seq_exp;
        logic r1, r2, rdy;

        bus.HBUSREQ_M1 = 1'b0;
        bus.HBUSREQ_M2 = 1'b0;
        bus.HREADY_S   = 1'b0;
        HRESETn        = 1'b0;
        model_reset();
        #2;
        check("reset_outputs", observe(), 9'b0);
        #10 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Single M1 transfer answered two cycles after grant.
        cyc(1, 0, 0, "m1_grant");
        cyc(0, 0, 0, "m1_wait");
        cyc(0, 0, 1, "m1_resp");
        cyc(0, 0, 0, "m1_idle");

        // Both masters saturating the bus: M1 wins once every MAX_WAIT+1 grants.
        for (int i = 0; i < 18; i++) begin
            cyc(1, 1, 1, "starve");
            seq_got[i] = (last_win == 1);
            seq_exp[i] = ((i % (MAX_WAIT + 1)) != MAX_WAIT);
        end
        check("starve_pattern", {1'b0, seq_got[8:0]}, {1'b0, seq_exp[8:0]});
        check("starve_repeat",  {1'b0, seq_got[17:9]}, {1'b0, seq_exp[17:9]});

        // Back-to-back M2 pipelined transfers.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, "b2b_m2");
        cyc(0, 0, 1, "b2b_drain");

        // Hung slave: M2 granted, stalls until the timeout; pending M1 waits one more cycle.
        cyc(0, 1, 0, "tmo_grant");
        for (int i = 1; i < TIMEOUT; i++) cyc(1, 0, 0, "tmo_stall");
        cyc(1, 0, 0, "tmo_fire");
        check("tmo_fire_const", last_obs, 9'b000110111);
        cyc(1, 0, 0, "tmo_m1_next");
        check("tmo_m1_const", last_obs, 9'b100001100);

        // Reset in the middle of an M1 data phase.
        bus.HBUSREQ_M1 = 1'b0;
        bus.HBUSREQ_M2 = 1'b0;
        bus.HREADY_S   = 1'b0;
        #1 HRESETn = 1'b0;
        #1;
        check("async_reset", observe(), 9'b0);
        model_reset();
        #2 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        cyc(0, 0, 1, "post_rst_ready");
        cyc(1, 0, 0, "post_rst_grant");
        cyc(0, 0, 1, "post_rst_resp");

        // Stray ready while idle.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, "idle_ready");

        // Random traffic; requests are held until granted.
        r1 = 1'b0; r2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom % 8) < 5;
            cyc(r1, r2, rdy, "random");
            if (last_win == 0 || !r1) r1 = ($urandom % 3) != 0;
            if (last_win == 1 || !r2) r2 = ($urandom % 3) != 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
